alu_arb_24: RTL

ALU_ARB_24 -- requirements
Module: alu_arb_24

---
 rtl/alu_arb_pkg.sv | 30 +++
 rtl/rr_arbiter_2.sv | 41 ++++
 rtl/alu_arb_24.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared widths, ALU op-codes and FSM encoding for the two-port ALU arbiter.
package alu_arb_pkg;

    localparam int DATA_W = 24;
    localparam int RES_W  = 25;
    localparam int OP_W   = 3;
    localparam int CNT_W  = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_DIV  = 3'b010;
    localparam logic [OP_W-1:0] OP_REM  = 3'b011;
    localparam logic [OP_W-1:0] OP_AND  = 3'b100;
    localparam logic [OP_W-1:0] OP_OR   = 3'b101;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b110;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // True when the operation would divide by zero and must not use the ALU.
    function automatic logic is_div_zero(input logic [OP_W-1:0] op,
                                         input logic [DATA_W-1:0] b);
        return ((op == OP_DIV) || (op == OP_REM)) && (b == '0);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: the pointer names the preferred requester and
// moves to the loser on every accepted grant.
module rr_arbiter_2 (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1,
    output logic grant_id,
    output logic accept
);

    logic pointer_reg;
    logic pick;

    // Lone requester wins outright; on contention the pointer decides.
    always_comb begin
        pick = valid1;
        if (valid0 && valid1) begin
            pick = pointer_reg;
        end
    end

    assign grant0   = enable && valid0 && !pick;
    assign grant1   = enable && valid1 && pick;
    assign grant_id = pick;
    assign accept   = grant0 || grant1;

    // Pointer advances only on an actual acceptance, so a requester that
    // withdraws before being granted leaves it untouched.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pointer_reg <= 1'b0;
        end else if (accept) begin
            pointer_reg <= !pick;
        end
    end

endmodule

// File: rtl/alu_arb_24.sv
// Arbitrates two requesters onto one shared pipelined 24-bit ALU and returns
// the result through a valid/ready response port, one transaction at a time.
module alu_arb_24
    import alu_arb_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [OP_W-1:0]   alu_select,
    input  logic [RES_W-1:0]  alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_err
);

    // Counter value on the edge where the ALU result is known to be settled.
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(ALU_LAT);

    state_t             state_reg;
    logic [CNT_W-1:0]   counter_reg;
    logic [DATA_W-1:0]  a_reg;
    logic [DATA_W-1:0]  b_reg;
    logic [OP_W-1:0]    op_reg;
    logic               dz_reg;
    logic               rsp_valid_reg;
    logic               rsp_id_reg;
    logic [RES_W-1:0]   rsp_data_reg;
    logic               rsp_err_reg;

    logic               arb_enable;
    logic               grant0;
    logic               grant1;
    logic               grant_id;
    logic               accept;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic [OP_W-1:0]    sel_op;

    // Grants are offered only while idle and out of reset.
    assign arb_enable = reset && (state_reg == IDLE);

    rr_arbiter_2 u_arb (
        .clock    (clock),
        .reset    (reset),
        .enable   (arb_enable),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .grant0   (grant0),
        .grant1   (grant1),
        .grant_id (grant_id),
        .accept   (accept)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Operand mux follows the arbitration winner.
    always_comb begin
        sel_a  = req0_a;
        sel_b  = req0_b;
        sel_op = req0_op;
        if (grant_id) begin
            sel_a  = req1_a;
            sel_b  = req1_b;
            sel_op = req1_op;
        end
    end

    assign alu_in1    = a_reg;
    assign alu_in2    = b_reg;
    assign alu_select = op_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_err    = rsp_err_reg;

    // Transaction FSM: latch on acceptance, wait out the ALU pipeline (or
    // short-circuit a divide by zero), then hold the response until taken.
    // A divide by zero leaves WAIT on its first edge, so its response is
    // registered one edge after acceptance instead of ALU_LAT+1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            counter_reg   <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            dz_reg        <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg       <= sel_a;
                        b_reg       <= sel_b;
                        op_reg      <= sel_op;
                        rsp_id_reg  <= grant_id;
                        dz_reg      <= is_div_zero(sel_op, sel_b);
                        counter_reg <= '0;
                        state_reg   <= WAIT;
                    end
                end
                WAIT: begin
                    if (dz_reg || (counter_reg == LAT_CNT)) begin
                        rsp_data_reg  <= dz_reg ? '0 : alu_out;
                        rsp_err_reg   <= dz_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        counter_reg <= counter_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
